// File: rtl/risc16_pkg.sv
// Shared risc16 fetch/decode definitions: widths, reset PC, fetch FSM states, PC select.
// Pure declarations; no latency or backpressure of its own.
package risc16_pkg;
  localparam int              PC_W     = 16;
  localparam int              INSTR_W  = 16;
  localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_LOAD = 2'd1,
    PC_INC  = 2'd2
  } pc_sel_t;
endpackage

// File: rtl/risc16_pc_reg.sv
// Program counter register with hold/load/increment select; async-reset to RESET_PC.
// New value visible one edge after the select; the caller chooses hold to stall.
module risc16_pc_reg
  import risc16_pkg::*;
#(
  parameter int              W     = PC_W,
  parameter logic [W-1:0]    RST_V = RESET_PC
) (
  input  logic         clk,
  input  logic         rst,
  input  pc_sel_t      sel,
  input  logic [W-1:0] load_pc,
  output logic [W-1:0] pc
);

  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    unique case (sel)
      PC_LOAD: pc_d = load_pc;
      PC_INC:  pc_d = pc_q + {{(W-1){1'b0}}, 1'b1};
      default: pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RST_V;
    else     pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/risc16_fetch_stage.sv
// risc16 instruction fetch: PC drives combinational imem, result lands in IF/ID one edge later.
// Stalls (PC and IF/ID hold) while id_valid && !id_ready; redirect flushes regardless.
module risc16_fetch_stage
  import risc16_pkg::*;
#(
  parameter logic [PC_W-1:0] RST_PC = RESET_PC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [15:0]        fetch_count
);

  fetch_state_t       state_q, state_d;
  logic               fetch_active;
  logic               load;
  pc_sel_t            pc_sel;
  logic [PC_W-1:0]    pc;

  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic [15:0]        fetch_count_q, fetch_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run_en)  state_d = RUN;
      RUN:     if (!run_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_active = (state_q == RUN);
  end

  assign load = fetch_active && run_en && !redirect_valid && (!id_valid_q || id_ready);

  // Redirect outranks everything, so a same-cycle id_ready does not consume the flushed entry.
  always_comb begin
    pc_sel        = PC_HOLD;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_sel     = PC_LOAD;
      id_valid_d = 1'b0;
    end else if (load) begin
      pc_sel        = PC_INC;
      id_valid_d    = 1'b1;
      id_instr_d    = imem_data;
      id_pc_d       = pc;
      fetch_count_d = fetch_count_q + 16'd1;
    end else if (id_valid_q && id_ready) begin
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q    <= 1'b0;
      id_instr_q    <= '0;
      id_pc_q       <= '0;
      fetch_count_q <= '0;
    end else begin
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  risc16_pc_reg #(
    .W     (PC_W),
    .RST_V (RST_PC)
  ) u_pc_reg (
    .clk     (clk),
    .rst     (rst),
    .sel     (pc_sel),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  assign imem_addr   = pc;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign fetch_count = fetch_count_q;

endmodule
